// File: rtl/mult_8x8_seq_ctrl_if.sv
// Handshake and shared-multiplier bus of the 8x8 sequential multiply controller.
// The slave modport is the controller's view; master is the surrounding system's view.
interface mult_8x8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_r;
    logic        busy;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic        mul_type;
    logic [7:0]  mul_r;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_r,
        output in_ready, out_valid, out_r, busy, mul_a, mul_b, mul_type
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_r,
        input  in_ready, out_valid, out_r, busy, mul_a, mul_b, mul_type
    );
endinterface

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequencer computing an (optionally approximate) 8x8 product by time-sharing
// one external combinational 4x4 multiplier over four partial products.
//
// state | meaning
// IDLE  | ready for an operand pair
// S_LL  | A[3:0]*B[3:0] on the shared unit, result into p_ll
// S_LH  | A[3:0]*B[7:4], folded into mid
// S_HL  | A[7:4]*B[3:0], folded into mid
// S_HH  | A[7:4]*B[7:4], final product assembled
// DONE  | product held until the consumer takes it
module mult_8x8_seq_ctrl #(
    parameter logic [3:0] MODE_MASK = 4'b0111,
    parameter bit         COMBINE   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mult_8x8_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_LL = 3'd1,
        S_LH = 3'd2,
        S_HL = 3'd3,
        S_HH = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  p_ll_q, p_ll_d;
    logic [7:0]  p_hh_q, p_hh_d;
    logic [8:0]  mid_q, mid_d;
    logic [15:0] out_r_q, out_r_d;
    logic        out_valid_q, out_valid_d;

    logic [8:0]  mid_next;
    logic [15:0] product;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            p_ll_q      <= '0;
            p_hh_q      <= '0;
            mid_q       <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_ll_q      <= p_ll_d;
            p_hh_q      <= p_hh_d;
            mid_q       <= mid_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand steering to the shared unit; kept apart from the register update so
    // the path mul_a/mul_b -> external unit -> mul_r never loops inside one process.
    always_comb begin
        bus.mul_a    = 4'h0;
        bus.mul_b    = 4'h0;
        bus.mul_type = 1'b0;
        case (state_q)
            S_LL: begin
                bus.mul_a    = a_q[3:0];
                bus.mul_b    = b_q[3:0];
                bus.mul_type = MODE_MASK[0];
            end
            S_LH: begin
                bus.mul_a    = a_q[3:0];
                bus.mul_b    = b_q[7:4];
                bus.mul_type = MODE_MASK[1];
            end
            S_HL: begin
                bus.mul_a    = a_q[7:4];
                bus.mul_b    = b_q[3:0];
                bus.mul_type = MODE_MASK[2];
            end
            S_HH: begin
                bus.mul_a    = a_q[7:4];
                bus.mul_b    = b_q[7:4];
                bus.mul_type = MODE_MASK[3];
            end
            default: ;
        endcase
    end

    // OR-combining the middle partials trades accuracy for a carry-free merge.
    assign mid_next = COMBINE ? (mid_q | {1'b0, bus.mul_r})
                              : (mid_q + {1'b0, bus.mul_r});

    // p_hh is still being written in S_HH, so the live mul_r stands in for it.
    assign product = {bus.mul_r, p_ll_q} + {3'b000, mid_q, 4'h0};

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        p_ll_d      = p_ll_q;
        p_hh_d      = p_hh_q;
        mid_d       = mid_q;
        out_r_d     = out_r_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    mid_d   = '0;
                    state_d = S_LL;
                end
            end
            S_LL: begin
                p_ll_d  = bus.mul_r;
                state_d = S_LH;
            end
            S_LH: begin
                mid_d   = mid_next;
                state_d = S_HL;
            end
            S_HL: begin
                mid_d   = mid_next;
                state_d = S_HH;
            end
            S_HH: begin
                p_hh_d      = bus.mul_r;
                out_r_d     = product;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_r     = out_r_q;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Bench for mult_8x8_seq_ctrl: an exact build and an approximate build run the same
// directed stimulus against a cycle-level reference model plus hand-computed literals.
module tb_mult_8x8_seq_ctrl;

    localparam logic [3:0] MASK_EX = 4'b0000;
    localparam logic [3:0] MASK_AP = 4'b0111;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;

    always #5 clk = ~clk;

    mult_8x8_seq_ctrl_if if_ex ();
    mult_8x8_seq_ctrl_if if_ap ();

    assign if_ex.in_valid  = in_valid;
    assign if_ex.in_a      = in_a;
    assign if_ex.in_b      = in_b;
    assign if_ex.out_ready = out_ready;
    assign if_ex.mul_r     = {4'h0, if_ex.mul_a} * {4'h0, if_ex.mul_b};

    assign if_ap.in_valid  = in_valid;
    assign if_ap.in_a      = in_a;
    assign if_ap.in_b      = in_b;
    assign if_ap.out_ready = out_ready;
    assign if_ap.mul_r     = {4'h0, if_ap.mul_a} * {4'h0, if_ap.mul_b};

    mult_8x8_seq_ctrl #(.MODE_MASK(MASK_EX), .COMBINE(1'b0)) u_ex (
        .clk (clk),
        .rst (rst),
        .bus (if_ex)
    );

    mult_8x8_seq_ctrl #(.MODE_MASK(MASK_AP), .COMBINE(1'b1)) u_ap (
        .clk (clk),
        .rst (rst),
        .bus (if_ap)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Product as defined by the partial-product recipe, in plain arithmetic.
    function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b, input bit comb);
        int ll, lh, hl, hh, mid, v;
        ll  = int'(a[3:0]) * int'(b[3:0]);
        lh  = int'(a[3:0]) * int'(b[7:4]);
        hl  = int'(a[7:4]) * int'(b[3:0]);
        hh  = int'(a[7:4]) * int'(b[7:4]);
        mid = comb ? (lh | hl) : (lh + hl);
        v   = hh * 256 + ll + mid * 16;
        return v[15:0];
    endfunction

    // Reference model: phase 0 = idle, 1..4 = the four multiply steps, 5 = result held.
    int          m_phase;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_r_ex, m_r_ap;
    int          cyc = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_a     = 8'h00;
            m_b     = 8'h00;
            m_r_ex  = 16'h0000;
            m_r_ap  = 16'h0000;
        end else begin
            cyc = cyc + 1;
            if (m_phase == 0) begin
                if (in_valid) begin
                    m_a     = in_a;
                    m_b     = in_b;
                    m_phase = 1;
                end
            end else if (m_phase < 4) begin
                m_phase = m_phase + 1;
            end else if (m_phase == 4) begin
                m_r_ex  = golden(m_a, m_b, 1'b0);
                m_r_ap  = golden(m_a, m_b, 1'b1);
                m_phase = 5;
            end else if (out_ready) begin
                m_phase = 0;
            end
        end
    end

    task automatic check_dut(input string tag, input logic ir, input logic bz, input logic ov,
                             input logic [15:0] r, input logic [3:0] ma, input logic [3:0] mb,
                             input logic mt, input logic [15:0] exp_r, input logic [3:0] mask);
        logic [3:0] ea, eb;
        logic       et;
        ea = 4'h0;
        eb = 4'h0;
        et = 1'b0;
        if (m_phase >= 1 && m_phase <= 4) begin
            ea = (m_phase <= 2) ? m_a[3:0] : m_a[7:4];
            eb = (m_phase == 1 || m_phase == 3) ? m_b[3:0] : m_b[7:4];
            et = mask[m_phase - 1];
        end
        chk({tag, "_in_ready"},  {31'd0, ir}, {31'd0, m_phase == 0});
        chk({tag, "_busy"},      {31'd0, bz}, {31'd0, m_phase != 0});
        chk({tag, "_out_valid"}, {31'd0, ov}, {31'd0, m_phase == 5});
        chk({tag, "_out_r"},     {16'd0, r},  {16'd0, exp_r});
        chk({tag, "_mul_a"},     {28'd0, ma}, {28'd0, ea});
        chk({tag, "_mul_b"},     {28'd0, mb}, {28'd0, eb});
        chk({tag, "_mul_type"},  {31'd0, mt}, {31'd0, et});
    endtask

    bit b2b_mode = 1'b0;
    int last_hs  = -1;
    int n_b2b    = 0;

    always @(negedge clk) begin
        check_dut("ex", if_ex.in_ready, if_ex.busy, if_ex.out_valid, if_ex.out_r,
                  if_ex.mul_a, if_ex.mul_b, if_ex.mul_type, m_r_ex, MASK_EX);
        check_dut("ap", if_ap.in_ready, if_ap.busy, if_ap.out_valid, if_ap.out_r,
                  if_ap.mul_a, if_ap.mul_b, if_ap.mul_type, m_r_ap, MASK_AP);
        if (b2b_mode && if_ap.out_valid && out_ready) begin
            if (last_hs >= 0) chk("b2b_gap", cyc - last_hs, 6);
            last_hs = cyc;
            n_b2b++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair for a single cycle; returns in cycle T+1.
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_step(input string name, input logic [3:0] ea, input logic [3:0] eb, input logic et);
        chk({name, "_a"},    {28'd0, if_ap.mul_a},    {28'd0, ea});
        chk({name, "_b"},    {28'd0, if_ap.mul_b},    {28'd0, eb});
        chk({name, "_type"}, {31'd0, if_ap.mul_type}, {31'd0, et});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        tick();
        tick();
        chk("rst_in_ready",  {31'd0, if_ex.in_ready},  1);
        chk("rst_out_valid", {31'd0, if_ex.out_valid}, 0);
        chk("rst_out_r",     {16'd0, if_ex.out_r},     0);
        chk("rst_busy",      {31'd0, if_ap.busy},      0);
        rst = 1'b0;
        tick();

        // 0xFF * 0xFF: exact and OR-combined results
        send(8'hFF, 8'hFF);
        tick(); tick(); tick();
        chk("t1_valid_T4", {31'd0, if_ex.out_valid}, 0);
        tick();
        chk("t1_valid_T5", {31'd0, if_ex.out_valid}, 1);
        chk("t1_ex_r",     {16'd0, if_ex.out_r},     32'hFE01);
        chk("t1_ap_r",     {16'd0, if_ap.out_r},     32'hEFF1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_idle", {31'd0, if_ex.in_ready}, 1);

        // 0x11 * 0x11: OR-merge loses the carry in the middle column
        send(8'h11, 8'h11);
        tick(); tick(); tick(); tick();
        chk("t2_ap_r", {16'd0, if_ap.out_r}, 32'h0111);
        chk("t2_ex_r", {16'd0, if_ex.out_r}, 32'h0121);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // step trace on the approximate build
        send(8'hA3, 8'h5C);
        chk_step("t3_s1", 4'h3, 4'hC, 1'b1);
        tick();
        chk_step("t3_s2", 4'h3, 4'h5, 1'b1);
        tick();
        chk_step("t3_s3", 4'hA, 4'hC, 1'b1);
        tick();
        chk_step("t3_s4", 4'hA, 4'h5, 1'b0);
        tick();
        chk("t3_ap_r", {16'd0, if_ap.out_r}, 32'h3A14);
        chk("t3_ex_r", {16'd0, if_ex.out_r}, 32'h3A94);

        // backpressure with a competing operand pair offered
        in_valid = 1'b1;
        in_a     = 8'h55;
        in_b     = 8'h66;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_hold_r",     {16'd0, if_ap.out_r},     32'h3A14);
            chk("t4_hold_valid", {31'd0, if_ap.out_valid}, 1);
            chk("t4_in_ready",   {31'd0, if_ap.in_ready},  0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_ready_after", {31'd0, if_ap.in_ready},  1);
        chk("t4_valid_after", {31'd0, if_ap.out_valid}, 0);
        chk("t4_r_kept",      {16'd0, if_ap.out_r},     32'h3A14);

        // reset in the middle of S_HL
        send(8'h77, 8'h88);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("t5_busy",     {31'd0, if_ap.busy},      0);
        chk("t5_in_ready", {31'd0, if_ap.in_ready},  1);
        chk("t5_out_r",    {16'd0, if_ap.out_r},     0);
        chk("t5_mul_a",    {28'd0, if_ap.mul_a},     0);
        chk("t5_mul_type", {31'd0, if_ap.mul_type},  0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_no_valid", {31'd0, if_ap.out_valid}, 0);
        end
        send(8'h02, 8'h03);
        tick(); tick(); tick(); tick();
        chk("t5_ap_r", {16'd0, if_ap.out_r}, 32'h0006);
        chk("t5_ex_r", {16'd0, if_ex.out_r}, 32'h0006);
        out_ready = 1'b1;
        tick();

        // back-to-back with random operands
        b2b_mode = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            in_a = 8'($urandom_range(0, 255));
            in_b = 8'($urandom_range(0, 255));
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        b2b_mode = 1'b0;
        chk("b2b_count", {31'd0, n_b2b >= 9}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
